// File: rtl/stream_arb_pkg.sv
// Shared constants and helpers for the stream arbiter/mux family.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package stream_arb_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first request at or above ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; grant is a pure function of req and ptr.
module rr_pick #(
    parameter int N      = 4,
    parameter int CHAN_W = 2
) (
    input  logic [N-1:0]      req,
    input  logic [CHAN_W-1:0] ptr,
    output logic [N-1:0]      gnt,
    output logic [CHAN_W-1:0] idx,
    output logic              any
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;

    // Rotate requests so ptr sits at bit 0, priority-encode, then rotate the index back.
    always_comb begin
        int pos;
        int sum;
        req2 = {req, req};
        rot  = N'(req2 >> ptr);
        pos  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) pos = k;
        end
        sum = pos + int'(ptr);
        if (sum >= N) sum = sum - N;
        any = |req;
        gnt = '0;
        idx = '0;
        if (any) begin
            gnt[sum] = 1'b1;
            idx      = CHAN_W'(sum);
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// N:1 valid/ready stream mux with round-robin or fixed-priority arbitration and packet locking.
// Latency: one cycle from input accept to io_out (single output register, full throughput).
// Backpressure: at most one input ready, only when the output register is empty or draining.
module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter  int N      = 4,
    parameter  int W      = 8,
    parameter  int MODE   = MODE_RR,
    localparam int CHAN_W = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      io_in_valid,
    output logic [N-1:0]      io_in_ready,
    input  logic [N*W-1:0]    io_in_bits,
    input  logic [N-1:0]      io_in_last,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [W-1:0]      io_out_bits,
    output logic              io_out_last,
    output logic [CHAN_W-1:0] io_out_chan
);

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_bits_q,  out_bits_d;
    logic              out_last_q,  out_last_d;
    logic [CHAN_W-1:0] out_chan_q,  out_chan_d;
    logic [CHAN_W-1:0] ptr_q,       ptr_d;
    logic              locked_q,    locked_d;
    logic [CHAN_W-1:0] lock_chan_q, lock_chan_d;

    logic [N-1:0]      cand;
    logic [N-1:0]      gnt;
    logic [CHAN_W-1:0] win;
    logic              win_any;
    logic [CHAN_W-1:0] pick_ptr;
    logic              load;
    logic              accept;

    // Candidate set: the locked channel alone mid-packet, otherwise every valid channel.
    always_comb begin
        cand = io_in_valid;
        if (locked_q) begin
            for (int i = 0; i < N; i++) begin
                cand[i] = (CHAN_W'(i) == lock_chan_q);
            end
        end
    end

    assign pick_ptr = (MODE == MODE_FIXED) ? '0 : ptr_q;

    rr_pick #(
        .N      (N),
        .CHAN_W (CHAN_W)
    ) u_pick (
        .req (cand),
        .ptr (pick_ptr),
        .gnt (gnt),
        .idx (win),
        .any (win_any)
    );

    // Handshake: the winner sees ready whenever the register can take a beat; nothing while in reset.
    always_comb begin
        load        = !out_valid_q || io_out_ready;
        io_in_ready = (load && reset && win_any) ? gnt : '0;
        accept      = |(io_in_valid & io_in_ready);
    end

    // Next-state: output register refill/drain, packet lock tracking and round-robin pointer advance.
    always_comb begin
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        locked_d    = locked_q;
        lock_chan_d = lock_chan_q;
        if (load) begin
            out_valid_d = accept;
        end
        if (accept) begin
            out_bits_d = io_in_bits[win*W +: W];
            out_last_d = io_in_last[win];
            out_chan_d = win;
            if (io_in_last[win]) begin
                locked_d = 1'b0;
                if (MODE == MODE_RR) begin
                    ptr_d = (win == CHAN_W'(N - 1)) ? '0 : win + CHAN_W'(1);
                end
            end else begin
                locked_d    = 1'b1;
                lock_chan_d = win;
            end
        end
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
            locked_q    <= 1'b0;
            lock_chan_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
            locked_q    <= locked_d;
            lock_chan_q <= lock_chan_d;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_out_bits  = out_bits_q;
    assign io_out_last  = out_last_q;
    assign io_out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: a round-robin and a fixed-priority instance share one stimulus stream.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: io_out_ready driven directed and randomly.
module tb_stream_arb_mux;
    import stream_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N*W-1:0] in_bits;
    logic           out_ready;

    logic [N-1:0]  o_rdy   [2];
    logic          o_valid [2];
    logic [W-1:0]  o_bits  [2];
    logic          o_last  [2];
    logic [CW-1:0] o_chan  [2];

    stream_arb_mux #(.N(N), .W(W), .MODE(MODE_RR)) u_rr (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (o_rdy[0]),
        .io_in_bits   (in_bits),
        .io_in_last   (in_last),
        .io_out_valid (o_valid[0]),
        .io_out_ready (out_ready),
        .io_out_bits  (o_bits[0]),
        .io_out_last  (o_last[0]),
        .io_out_chan  (o_chan[0])
    );

    stream_arb_mux #(.N(N), .W(W), .MODE(MODE_FIXED)) u_fp (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (o_rdy[1]),
        .io_in_bits   (in_bits),
        .io_in_last   (in_last),
        .io_out_valid (o_valid[1]),
        .io_out_ready (out_ready),
        .io_out_bits  (o_bits[1]),
        .io_out_last  (o_last[1]),
        .io_out_chan  (o_chan[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model state per instance (index 0 = round-robin, 1 = fixed priority).
    int           m_ptr  [2];
    bit           m_lock [2];
    int           m_lch  [2];
    bit           m_ov   [2];
    logic [W-1:0] m_ob   [2];
    bit           m_ol   [2];
    int           m_oc   [2];
    bit           p_load [2];
    bit           p_acc  [2];
    int           p_win  [2];
    logic [N-1:0] p_rdy  [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0; m_lock[m] = 0; m_lch[m] = 0;
            m_ov[m] = 0; m_ob[m] = '0; m_ol[m] = 0; m_oc[m] = 0;
        end
    endtask

    // Decide this cycle's winner from the current inputs.
    task automatic model_pre();
        for (int m = 0; m < 2; m++) begin
            bit has;
            int win;
            has = 0;
            win = 0;
            p_load[m] = !m_ov[m] || out_ready;
            if (m_lock[m]) begin
                has = 1;
                win = m_lch[m];
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m == 0) ? (m_ptr[m] + k) % N : k;
                    if (!has && in_valid[c]) begin
                        has = 1;
                        win = c;
                    end
                end
            end
            p_win[m] = win;
            p_rdy[m] = (has && p_load[m] && reset) ? (N'(1) << win) : '0;
            p_acc[m] = has && p_load[m] && reset && in_valid[win];
        end
    endtask

    // Apply the decided transfer at the clock edge.
    task automatic model_post();
        for (int m = 0; m < 2; m++) begin
            if (p_load[m]) m_ov[m] = p_acc[m];
            if (p_acc[m]) begin
                m_ob[m] = in_bits[p_win[m]*W +: W];
                m_ol[m] = in_last[p_win[m]];
                m_oc[m] = p_win[m];
                if (in_last[p_win[m]]) begin
                    m_lock[m] = 0;
                    if (m == 0) m_ptr[m] = (p_win[m] + 1) % N;
                end else begin
                    m_lock[m] = 1;
                    m_lch[m]  = p_win[m];
                end
            end
        end
    endtask

    task automatic check_out();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("out_valid[%0d]", m), o_valid[m], m_ov[m]);
            check($sformatf("out_bits[%0d]", m), o_bits[m], m_ob[m]);
            check($sformatf("out_last[%0d]", m), o_last[m], m_ol[m]);
            check($sformatf("out_chan[%0d]", m), o_chan[m], m_oc[m]);
        end
    endtask

    // One clock: inputs were set at the falling edge by the caller.
    task automatic cycle();
        #1;
        model_pre();
        for (int m = 0; m < 2; m++) check($sformatf("in_ready[%0d]", m), o_rdy[m], p_rdy[m]);
        @(posedge clock);
        model_post();
        @(negedge clock);
        check_out();
    endtask

    task automatic set_bits(input int ch, input logic [W-1:0] v);
        in_bits[ch*W +: W] = v;
    endtask

    initial begin
        in_valid  = '1;
        in_last   = '1;
        in_bits   = {8'h33, 8'h22, 8'h11, 8'h00};
        out_ready = 1'b1;
        reset     = 1'b0;
        model_reset();

        // Reset held with every channel valid.
        repeat (3) @(negedge clock);
        for (int m = 0; m < 2; m++) begin
            check("rst_valid", o_valid[m], 0);
            check("rst_ready", o_rdy[m], 0);
            check("rst_chan", o_chan[m], 0);
        end
        reset = 1'b1;

        // Round-robin fairness: 0,1,2,3,0 with no bubbles.
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_chan", o_chan[0], i % 4);
            check("rr_valid", o_valid[0], 1);
            check("rr_bits", o_bits[0], 32'((i % 4) * 17));
        end

        // Fixed priority: channels 1 and 3 contend, 1 always wins.
        in_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("fp_chan", o_chan[1], 1);
            check("fp_rdy1", o_rdy[1][1], 1);
            check("fp_rdy3", o_rdy[1][3], 0);
        end

        // Packet lock on channel 2 with a gap, channel 0 waiting.
        in_last = 4'b0000; in_valid = 4'b0100; set_bits(2, 8'hC1);
        cycle();
        check("lk_chan0", o_chan[0], 2);
        in_valid = 4'b0101; set_bits(2, 8'hC2);
        cycle();
        check("lk_chan1", o_chan[0], 2);
        in_valid = 4'b0001;
        cycle();
        check("lk_bubble", o_valid[0], 0);
        in_valid = 4'b0101; in_last = 4'b0100; set_bits(2, 8'hC3);
        cycle();
        check("lk_chan3", o_chan[0], 2);
        check("lk_bits3", o_bits[0], 8'hC3);
        in_valid = 4'b0001; in_last = 4'b1111;
        cycle();
        check("lk_after", o_chan[0], 0);

        // Backpressure: held beat 0xA5 stays put, nothing is offered ready.
        in_valid = 4'b0010; set_bits(1, 8'hA5);
        cycle();
        check("bp_load", o_bits[0], 8'hA5);
        out_ready = 1'b0; in_valid = 4'b1111; set_bits(1, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_bits", o_bits[0], 8'hA5);
            check("bp_chan", o_chan[0], 1);
            check("bp_last", o_last[0], 1);
            check("bp_rdy", o_rdy[0], 0);
        end
        out_ready = 1'b1; in_valid = 4'b1000; set_bits(3, 8'h3C);
        #1;
        check("bp_restore_rdy", o_rdy[0], 4'b1000);
        cycle();
        check("bp_restore_bits", o_bits[0], 8'h3C);
        check("bp_restore_chan", o_chan[0], 3);

        // Async reset in the middle of a channel-1 packet.
        in_valid = 4'b0010; in_last = 4'b0000; set_bits(1, 8'h51);
        cycle();
        check("ar_pre_chan", o_chan[0], 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_out();
        check("ar_valid", o_valid[0], 0);
        check("ar_bits", o_bits[0], 0);
        @(negedge clock);
        reset = 1'b1;
        in_valid = 4'b0011; in_last = 4'b1111;
        cycle();
        check("ar_post_chan", o_chan[0], 0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = N'($urandom);
            in_last   = N'($urandom) | N'($urandom);
            in_bits   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
